// File: rtl/mul_datapath.sv
// mul_datapath: shift-add multiplier datapath, responder to the multiplier controller.
// Loads operands on w_ctrl, adds the multiplicand into the upper product half on
// addu_ctrl == ADDU_FN, shifts {carry, product} right on srl_ctrl, and flags done
// once the controller raises ready.
// Optional feature macro: MUL_DP_STEP_CHECK_EN adds step_cnt and proto_err outputs.
module mul_datapath #(
    parameter int unsigned WIDTH   = 32,
    parameter logic [5:0]  ADDU_FN = 6'b001001
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    input  logic                 w_ctrl,
    input  logic [5:0]           addu_ctrl,
    input  logic                 srl_ctrl,
    input  logic                 ready,
    output logic                 lsb,
    output logic [2*WIDTH-1:0]   product,
    output logic                 done
`ifdef MUL_DP_STEP_CHECK_EN
    ,
    output logic [$clog2(WIDTH+1)-1:0] step_cnt,
    output logic                       proto_err
`endif
);

    localparam int unsigned PW = 2 * WIDTH;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [PW-1:0]    prod_q,  prod_d;
    logic             carry_q, carry_d;
    logic             done_q,  done_d;

    logic             add_en;
    logic [WIDTH:0]   sum;

    // Add term and decoded add enable
    assign add_en = (addu_ctrl == ADDU_FN);
    assign sum    = {1'b0, prod_q[PW-1:WIDTH]} + {1'b0, mcand_q};

    // Next-state: load beats add/shift, which beats hold
    always_comb begin
        mcand_d = mcand_q;
        prod_d  = prod_q;
        carry_d = carry_q;
        done_d  = done_q;
        if (w_ctrl) begin
            mcand_d = multiplicand;
            prod_d  = {{WIDTH{1'b0}}, multiplier};
            carry_d = 1'b0;
            done_d  = 1'b0;
        end else begin
            if (add_en && srl_ctrl) begin
                // fused add-then-shift: carry out lands in the product MSB
                {carry_d, prod_d} = {1'b0, sum, prod_q[WIDTH-1:1]};
            end else if (add_en) begin
                prod_d[PW-1:WIDTH] = sum[WIDTH-1:0];
                carry_d            = sum[WIDTH];
            end else if (srl_ctrl) begin
                {carry_d, prod_d} = {1'b0, carry_q, prod_q[PW-1:1]};
            end
            if (ready) begin
                done_d = 1'b1;
            end
        end
    end

    // Datapath state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q <= '0;
            prod_q  <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign lsb     = prod_q[0];
    assign product = prod_q;
    assign done    = done_q;

`ifdef MUL_DP_STEP_CHECK_EN
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic [CNT_W-1:0] step_cnt_q, step_cnt_d;
    logic             proto_err_q, proto_err_d;
    logic             at_full;

    assign at_full = (step_cnt_q == CNT_W'(WIDTH));

    // Shift counter (saturating) and sticky protocol-error flag
    always_comb begin
        step_cnt_d  = step_cnt_q;
        proto_err_d = proto_err_q;
        if (w_ctrl) begin
            step_cnt_d  = '0;
            proto_err_d = 1'b0;
        end else begin
            if (srl_ctrl && !at_full) begin
                step_cnt_d = step_cnt_q + CNT_W'(1);
            end
            if ((srl_ctrl && at_full) || (ready && !at_full)) begin
                proto_err_d = 1'b1;
            end
        end
    end

    // Step-check registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_cnt_q  <= '0;
            proto_err_q <= 1'b0;
        end else begin
            step_cnt_q  <= step_cnt_d;
            proto_err_q <= proto_err_d;
        end
    end

    assign step_cnt  = step_cnt_q;
    assign proto_err = proto_err_q;
`endif

endmodule

// File: doc/mul_datapath.md
# mul_datapath

Shift-add multiplier datapath: the responder side of the multiplier controller's handshake. It loads operands on `w_ctrl` and conditionally adds the multiplicand into the upper product half on `addu_ctrl`. It shifts the {carry, product} register right on `srl_ctrl`, feeds the current product LSB back to the controller on `lsb`, and holds the final product once the controller raises `ready`. It sits beside the controller inside the PA1 multiplier top level.

## Interface
- `WIDTH`, default 32, operand width; the product is 2*WIDTH bits.
- `ADDU_FN`, default 6'b001001, the `addu_ctrl` code that enables the add.
- `clk`  input  1  clock; all state updates on the rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `multiplicand`  input  WIDTH  operand, sampled only when `w_ctrl`=1.
- `multiplier`  input  WIDTH  operand, sampled only when `w_ctrl`=1.
- `w_ctrl`  input  1  load operands and clear accumulator.
- `addu_ctrl`  input  6  add-enable code; the add occurs only when it equals `ADDU_FN`.
- `srl_ctrl`  input  1  shift {carry, prod_hi, prod_lo} right by one.
- `ready`  input  1  controller signals the multiply is complete.
- `lsb`  output  1  prod_lo[0], driven from the register (no combinational path from inputs).
- `product`  output  2*WIDTH  {prod_hi, prod_lo}, a direct register view.
- `done`  output  1  the product is final.

## Operation
- State: `mcand_r`[WIDTH], `prod_r`[2*WIDTH], `carry_r`[1], `done_r`[1].
- Reset (asynchronous) clears all state to 0, so `lsb`=0, `product`=0, `done`=0.
- Priority per edge: `w_ctrl` > (add/shift) > hold.
- On `w_ctrl`=1:
  - `mcand_r`←`multiplicand`, `prod_r`←{WIDTH'b0, `multiplier`}, `carry_r`←0, `done_r`←0.
  - `addu_ctrl`, `srl_ctrl` and `ready` are ignored that cycle.
- Add term: sum[WIDTH:0] = {1'b0, prod_hi} + {1'b0, `mcand_r`}, unsigned (unsigned is fixed; no signed mode).
- Add only (`addu_ctrl`==`ADDU_FN`, `srl_ctrl`=0): prod_hi←sum[WIDTH-1:0], `carry_r`←sum[WIDTH].
- Shift only (`srl_ctrl`=1, no add): {`carry_r`, `prod_r`}←{1'b0, `carry_r`, `prod_r`[2*WIDTH-1:1]}.
- Add and shift in the same cycle: {`carry_r`, `prod_r`}←{1'b0, sum, prod_lo[WIDTH-1:1]}, i.e. add then shift, fused.
- Any `addu_ctrl` value other than `ADDU_FN`: no add.
- `done_r`←1 on an edge with `ready`=1 and `w_ctrl`=0. It stays 1 until the next `w_ctrl` or reset.
- `ready` does not freeze `prod_r`; the controller must stop issuing `addu`/`srl` commands.

## Timing
- Each command takes effect at the edge where it is sampled. `lsb` reflects the new `prod_r`[0] in the following cycle.
- Controller contract: an `lsb` sampled in cycle n decides the `addu_ctrl` applied in cycle n. One iteration is either a fused add+shift cycle or an add cycle followed by a shift cycle. Both orderings give identical products.
- A full multiply is 1 load cycle plus WIDTH iterations. `product` is valid at the edge after the last shift, and `done` rises one edge after `ready` is sampled high.
- Reset mid-operation clears everything immediately. It is not cycle-aligned.
- No overflow is possible: the 2*WIDTH product holds every unsigned WIDTH×WIDTH result.

## Configuration
- `MUL_DP_STEP_CHECK_EN`: defined, the block adds
  - output `step_cnt`[$clog2(WIDTH+1)], which counts shifts since the last load, cleared by `w_ctrl` and reset, and saturates at WIDTH;
  - output `proto_err`, a sticky flag that sets on a shift while `step_cnt`==WIDTH, or on `ready`=1 while `step_cnt`!=WIDTH. It clears only on `w_ctrl` or reset.
- Not defined: neither port exists, and datapath behaviour is identical.

## Test plan
- Load 3×5, then 32 fused iterations with `addu_ctrl`=`ADDU_FN` when `lsb`=1, then `ready` → `product`=64'h0000_0000_0000_000F; `done`=1 one edge after `ready`.
- Load 32'hFFFF_FFFF×32'hFFFF_FFFF, split add/shift cycles → `carry_r` is exercised and `product`=64'hFFFF_FFFE_0000_0001.
- Add then shift on separate cycles vs. fused cycles for 32'h1234_5678×32'h9ABC_DEF0 → both give 64'h0B00_EA4E_242D_2080.
- `w_ctrl`=1 with `srl_ctrl`=1 and `addu_ctrl`=`ADDU_FN` in the same cycle → load wins: `prod_r`={32'b0, multiplier}, `done`=0.
- `addu_ctrl`=6'b100001 with `lsb`=1 → no add, only a shift when `srl_ctrl`=1.
- Assert `reset` mid-multiply (after 10 shifts) → `product`=0, `lsb`=0 and `done`=0 immediately. With `MUL_DP_STEP_CHECK_EN`, `step_cnt`=0; a 33rd shift after reload sets `proto_err`.
